template_arith_pipe: RTL and testbench



---
 rtl/template_arith_pkg.sv | 27 ++
 rtl/template_arith_core.sv | 46 ++++
 rtl/template_arith_pipe.sv | 88 ++++++++
 tb/tb_template_arith_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/template_arith_pkg.sv
// Shared types for the template arithmetic pipe: opcode encoding and the
// per-result status flags carried alongside each result through the stages.
package template_arith_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    ADD     = 2'd0,
    SUB     = 2'd1,
    ABSDIFF = 2'd2,
    SAT_ADD = 2'd3
  } op_e;

  typedef struct packed {
    logic carry;
    logic sat;
    logic zero;
  } flags_t;

  localparam int FLAG_W = $bits(flags_t);

  // Packed width of one stage slot (valid + result + flags) for a given width.
  function automatic int stage_w(int width);
    return 1 + width + FLAG_W;
  endfunction

endpackage

// File: rtl/template_arith_core.sv
// Combinational stage-1 compute: one WIDTH+1 bit adder and subtractor shared
// by all four opcodes, with the carry/borrow/overflow taken from the top bit.
module template_arith_core
  import template_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sat,
  output logic             zero
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    result = sum[WIDTH-1:0];
    carry  = 1'b0;
    sat    = 1'b0;
    case (op)
      ADD: carry = sum[WIDTH];
      SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      ABSDIFF: result = diff[WIDTH] ? (b - a) : diff[WIDTH-1:0];
      SAT_ADD: begin
        result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        sat    = sum[WIDTH];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/template_arith_pipe.sv
// Pipelined two-operand arithmetic unit: compute in stage 1, then DEPTH-1
// carry-only stages, all moving together under a single global stall.
module template_arith_pipe
  import template_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_sat,
  output logic             out_zero,
  output logic [CNT_W-1:0] result_count
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] result;
    flags_t           flags;
  } stage_t;

  stage_t           st [DEPTH];
  stage_t           st_in;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_sat;
  logic             core_zero;
  logic             advance;
  logic [CNT_W-1:0] cnt;

  template_arith_core #(.WIDTH(WIDTH)) u_core (
    .op     (op_e'(in_op)),
    .a      (in_a),
    .b      (in_b),
    .result (core_result),
    .carry  (core_carry),
    .sat    (core_sat),
    .zero   (core_zero)
  );

  always_comb begin
    st_in             = '0;
    st_in.valid       = in_valid;
    st_in.result      = core_result;
    st_in.flags.carry = core_carry;
    st_in.flags.sat   = core_sat;
    st_in.flags.zero  = core_zero;
  end

  // Whole pipe moves as one; in_ready follows out_ready combinationally.
  assign advance  = !st[DEPTH-1].valid || out_ready;
  assign in_ready = advance;

  // NOTE: the stage array is reset on purpose: valid and the visible result
  // and flags must clear asynchronously, so this is not a plain storage RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) st[i] <= '0;
      cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, so the shift order inside the loop is moot.
      if (advance) begin
        st[0] <= st_in;
        for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
      end
      if (st[DEPTH-1].valid && out_ready) cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid    = st[DEPTH-1].valid;
  assign out_result   = st[DEPTH-1].result;
  assign out_carry    = st[DEPTH-1].flags.carry;
  assign out_sat      = st[DEPTH-1].flags.sat;
  assign out_zero     = st[DEPTH-1].flags.zero;
  assign result_count = cnt;

endmodule

// File: tb/tb_template_arith_pipe.sv
// Directed bench for template_arith_pipe at WIDTH=8, DEPTH=2: opcodes, flags,
// latency, backpressure, streaming and asynchronous reset mid-stream.
module tb_template_arith_pipe;
  import template_arith_pkg::*;

  localparam int W = 8;
  localparam int D = 2;
  localparam int C = 16;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_sat;
  logic         out_zero;
  logic [C-1:0] result_count;

  int passed = 0;
  int total  = 0;

  template_arith_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_sat      (out_sat),
    .out_zero     (out_zero),
    .result_count (result_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one operand pair and hold it until the accepting edge has passed.
  task automatic send(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, check it, and consume it with out_ready=1.
  task automatic expect_out(input string tag, input logic [W-1:0] res,
                            input logic c, input logic s, input logic z);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"},   32'(out_result), 32'(res));
    check({tag, "_carry"}, 32'(out_carry), 32'(c));
    check({tag, "_sat"},   32'(out_sat), 32'(s));
    check({tag, "_zero"},  32'(out_zero), 32'(z));
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'd0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(result_count), 32'd0);
    check("rst_zero", 32'(out_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // SUB 5-5: exact two-cycle latency, zero flag, counter
    in_valid = 1'b1;
    in_op    = SUB;
    in_a     = 8'd5;
    in_b     = 8'd5;
    check("lat_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("sub55_res", 32'(out_result), 32'd0);
    check("sub55_zero", 32'(out_zero), 32'd1);
    check("sub55_carry", 32'(out_carry), 32'd0);
    tick();
    check("sub55_count", 32'(result_count), 32'd1);
    check("sub55_drained", 32'(out_valid), 32'd0);

    // Opcode vectors
    send(ADD, 8'd200, 8'd100);
    expect_out("add_ovf", 8'd44, 1'b1, 1'b0, 1'b0);
    send(SAT_ADD, 8'd200, 8'd100);
    expect_out("sat_ovf", 8'd255, 1'b0, 1'b1, 1'b0);
    send(SAT_ADD, 8'd100, 8'd50);
    expect_out("sat_noovf", 8'd150, 1'b0, 1'b0, 1'b0);
    send(ABSDIFF, 8'd3, 8'd10);
    expect_out("abs_3_10", 8'd7, 1'b0, 1'b0, 1'b0);
    send(ABSDIFF, 8'd10, 8'd3);
    expect_out("abs_10_3", 8'd7, 1'b0, 1'b0, 1'b0);
    send(SUB, 8'd3, 8'd10);
    expect_out("sub_borrow", 8'd249, 1'b1, 1'b0, 1'b0);
    send(ADD, 8'd255, 8'd1);
    expect_out("add_wrap0", 8'd0, 1'b1, 1'b0, 1'b1);
    check("ops_count", 32'(result_count), 32'd8);

    // Backpressure: two accepts fill the pipe, the third waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = ADD;
    in_a      = 8'd1;
    in_b      = 8'd1;
    check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    in_a = 8'd2;
    in_b = 8'd2;
    check("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    in_a = 8'd3;
    in_b = 8'd3;
    check("bp_stall", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("bp_hold_rdy", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_res", 32'(out_result), 32'd2);
    check("bp_hold_count", 32'(result_count), 32'd8);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_out2_res", 32'(out_result), 32'd4);
    check("bp_out2_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_out3_res", 32'(out_result), 32'd6);
    check("bp_out3_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_count", 32'(result_count), 32'd11);

    // Streaming: 20 back-to-back ADDs, one result every cycle
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        in_valid = 1'b1;
        in_op    = ADD;
        in_a     = 8'(c);
        in_b     = 8'(2 * c);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) begin
        check($sformatf("stream_valid_%0d", c - 2), 32'(out_valid), 32'd1);
        check($sformatf("stream_res_%0d", c - 2), 32'(out_result), 32'(3 * (c - 2)));
      end else begin
        check($sformatf("stream_fill_%0d", c), 32'(out_valid), 32'd0);
      end
      tick();
    end
    check("stream_empty", 32'(out_valid), 32'd0);
    check("stream_count", 32'(result_count), 32'd31);

    // Asynchronous reset with two results in flight
    in_valid = 1'b1;
    in_op    = ADD;
    in_a     = 8'd1;
    in_b     = 8'd1;
    tick();
    in_a = 8'd2;
    in_b = 8'd2;
    tick();
    in_valid = 1'b0;
    check("inflight_valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_count", 32'(result_count), 32'd0);
    check("arst_result", 32'(out_result), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(SUB, 8'd9, 8'd4);
    expect_out("post_rst_sub", 8'd5, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", 32'(result_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
